// File: rtl/ex_stage_if.sv
// ID/EX inputs, MEM/WB forwarding source, pipeline control and EX/MEM register outputs of the execute stage.
interface ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [3:0]        Ex;
  logic              MemR;
  logic              MemW;
  logic [1:0]        Wb;
  logic [REG_AW-1:0] RegRs;
  logic [REG_AW-1:0] RegRt;
  logic [REG_AW-1:0] RegRd;
  logic [DATA_W-1:0] Exsign_extend;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              WbRegWrite;
  logic [REG_AW-1:0] WbRd;
  logic [DATA_W-1:0] WbData;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] ExmAlu;
  logic [DATA_W-1:0] ExmStore;
  logic [REG_AW-1:0] ExmRd;
  logic              ExmMemR;
  logic              ExmMemW;
  logic [1:0]        ExmWb;
  logic              ExmZero;
  logic              ExmOvf;

  modport master (
    output Ex, MemR, MemW, Wb, RegRs, RegRt, RegRd, Exsign_extend, data1, data2,
           WbRegWrite, WbRd, WbData, stall, flush,
    input  ExmAlu, ExmStore, ExmRd, ExmMemR, ExmMemW, ExmWb, ExmZero, ExmOvf
  );

  modport slave (
    input  Ex, MemR, MemW, Wb, RegRs, RegRt, RegRd, Exsign_extend, data1, data2,
           WbRegWrite, WbRd, WbData, stall, flush,
    output ExmAlu, ExmStore, ExmRd, ExmMemR, ExmMemW, ExmWb, ExmZero, ExmOvf
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU control decode, ALU, EX/MEM register.
// Latency 1 cycle; stall holds the EX/MEM register, flush bubbles its control fields and overrides stall.
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic     clk,
  input logic     rst,
  ex_stage_if.slave bus
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  logic              reg_dst;
  logic [1:0]        alu_op_sel;
  logic              alu_src;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] result;
  logic              ovf;
  logic              slt_bit;
  logic [REG_AW-1:0] dest;
  alu_op_t           op;

  assign reg_dst    = bus.Ex[3];
  assign alu_op_sel = bus.Ex[2:1];
  assign alu_src    = bus.Ex[0];

  // EX/MEM wins over MEM/WB because it holds the younger value; $0 never forwards.
  always_comb begin
    fwd_a = bus.data1;
    if (bus.ExmWb[1] && (bus.ExmRd != '0) && (bus.ExmRd == bus.RegRs))
      fwd_a = bus.ExmAlu;
    else if (bus.WbRegWrite && (bus.WbRd != '0) && (bus.WbRd == bus.RegRs))
      fwd_a = bus.WbData;
  end

  always_comb begin
    fwd_b = bus.data2;
    if (bus.ExmWb[1] && (bus.ExmRd != '0) && (bus.ExmRd == bus.RegRt))
      fwd_b = bus.ExmAlu;
    else if (bus.WbRegWrite && (bus.WbRd != '0) && (bus.WbRd == bus.RegRt))
      fwd_b = bus.WbData;
  end

  assign opnd_b = alu_src ? bus.Exsign_extend : fwd_b;
  assign dest   = reg_dst ? bus.RegRd : bus.RegRt;

  always_comb begin
    op = ALU_ADD;
    case (alu_op_sel)
      2'b01: op = ALU_SUB;
      2'b10: begin
        case (bus.Exsign_extend[5:0])
          6'b100010: op = ALU_SUB;
          6'b100100: op = ALU_AND;
          6'b100101: op = ALU_OR;
          6'b101010: op = ALU_SLT;
          default:   op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  assign sum     = fwd_a + opnd_b;
  assign diff    = fwd_a - opnd_b;
  assign slt_bit = $signed(fwd_a) < $signed(opnd_b);

  always_comb begin
    result = sum;
    ovf    = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum;
        ovf    = (fwd_a[DATA_W-1] == opnd_b[DATA_W-1]) && (sum[DATA_W-1] != fwd_a[DATA_W-1]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (fwd_a[DATA_W-1] != opnd_b[DATA_W-1]) && (diff[DATA_W-1] != fwd_a[DATA_W-1]);
      end
      ALU_AND: result = fwd_a & opnd_b;
      ALU_OR:  result = fwd_a | opnd_b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, slt_bit};
      default: result = sum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ExmAlu   <= '0;
      bus.ExmStore <= '0;
      bus.ExmRd    <= '0;
      bus.ExmMemR  <= 1'b0;
      bus.ExmMemW  <= 1'b0;
      bus.ExmWb    <= 2'b00;
      bus.ExmZero  <= 1'b0;
      bus.ExmOvf   <= 1'b0;
    end else if (bus.flush || !bus.stall) begin
      bus.ExmAlu   <= result;
      bus.ExmStore <= fwd_b;
      bus.ExmRd    <= dest;
      bus.ExmZero  <= (result == '0);
      bus.ExmOvf   <= ovf;
      bus.ExmMemR  <= bus.flush ? 1'b0 : bus.MemR;
      bus.ExmMemW  <= bus.flush ? 1'b0 : bus.MemW;
      bus.ExmWb    <= bus.flush ? 2'b00 : bus.Wb;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized checks of ex_stage against an arithmetic reference model of the EX/MEM register.
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if ifc ();
  ex_stage dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        memr;
    logic        memw;
    logic [1:0]  wb;
    logic        zero;
    logic        ovf;
  } exm_t;

  exm_t m;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [5:0] functs [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".alu"},   ifc.ExmAlu,   m.alu);
    check({tag, ".store"}, ifc.ExmStore, m.store);
    check({tag, ".rd"},    32'(ifc.ExmRd), 32'(m.rd));
    check({tag, ".memr"},  32'(ifc.ExmMemR), 32'(m.memr));
    check({tag, ".memw"},  32'(ifc.ExmMemW), 32'(m.memw));
    check({tag, ".wb"},    32'(ifc.ExmWb), 32'(m.wb));
    check({tag, ".zero"},  32'(ifc.ExmZero), 32'(m.zero));
    check({tag, ".ovf"},   32'(ifc.ExmOvf), 32'(m.ovf));
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
    if (m.wb[1] && m.rd != 0 && m.rd == r) return m.alu;
    if (ifc.WbRegWrite && ifc.WbRd != 0 && ifc.WbRd == r) return ifc.WbData;
    return rf;
  endfunction

  // Reference: signed 64-bit arithmetic, overflow = result does not fit in 32 bits.
  function automatic exm_t model_next();
    exm_t n;
    logic [31:0] a, bf, b, res;
    longint full;
    int op;
    n  = m;
    a  = fwd(ifc.RegRs, ifc.data1);
    bf = fwd(ifc.RegRt, ifc.data2);
    b  = ifc.Ex[0] ? ifc.Exsign_extend : bf;
    op = 0;
    if (ifc.Ex[2:1] == 2'b01) op = 1;
    else if (ifc.Ex[2:1] == 2'b10) begin
      if (ifc.Exsign_extend[5:0] == 6'd34) op = 1;
      else if (ifc.Exsign_extend[5:0] == 6'd36) op = 2;
      else if (ifc.Exsign_extend[5:0] == 6'd37) op = 3;
      else if (ifc.Exsign_extend[5:0] == 6'd42) op = 4;
    end
    full = 0;
    case (op)
      0: full = longint'($signed(a)) + longint'($signed(b));
      1: full = longint'($signed(a)) - longint'($signed(b));
      2: full = longint'(a & b);
      3: full = longint'(a | b);
      default: full = ($signed(a) < $signed(b)) ? 1 : 0;
    endcase
    res = full[31:0];
    if (ifc.flush || !ifc.stall) begin
      n.alu   = res;
      n.store = bf;
      n.rd    = ifc.Ex[3] ? ifc.RegRd : ifc.RegRt;
      n.zero  = (res == 0);
      n.ovf   = (op <= 1) && (full != longint'($signed(res)));
      n.memr  = ifc.flush ? 1'b0 : ifc.MemR;
      n.memw  = ifc.flush ? 1'b0 : ifc.MemW;
      n.wb    = ifc.flush ? 2'b00 : ifc.Wb;
    end
    return n;
  endfunction

  task automatic cycle(input string tag);
    exm_t nxt;
    nxt = model_next();
    @(posedge clk);
    #1;
    m = nxt;
    check_all(tag);
  endtask

  task automatic idle();
    ifc.Ex = 4'b0; ifc.MemR = 0; ifc.MemW = 0; ifc.Wb = 2'b0;
    ifc.RegRs = 0; ifc.RegRt = 0; ifc.RegRd = 0; ifc.Exsign_extend = 0;
    ifc.data1 = 0; ifc.data2 = 0; ifc.WbRegWrite = 0; ifc.WbRd = 0; ifc.WbData = 0;
    ifc.stall = 0; ifc.flush = 0;
  endtask

  initial begin
    functs[0] = 6'd32; functs[1] = 6'd34; functs[2] = 6'd36;
    functs[3] = 6'd37; functs[4] = 6'd42; functs[5] = 6'd7;
    m = '0;
    idle();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // R-type add 5 + 7 into $3
    ifc.data1 = 5; ifc.data2 = 7; ifc.Ex = 4'b1100; ifc.Exsign_extend = 32'h20; ifc.RegRd = 3;
    cycle("radd");
    check("radd.const", ifc.ExmAlu, 32'd12);

    // forwarding priority: EX/MEM ($2 = 9) beats MEM/WB ($2 = 4)
    @(negedge clk); idle();
    ifc.data1 = 4; ifc.data2 = 5; ifc.Ex = 4'b1000; ifc.RegRd = 2; ifc.Wb = 2'b10;
    cycle("fwd_setup");
    @(negedge clk); idle();
    ifc.WbRegWrite = 1; ifc.WbRd = 2; ifc.WbData = 4; ifc.RegRs = 2; ifc.Ex = 4'b1000; ifc.RegRd = 5;
    cycle("fwd_prio");
    check("fwd_prio.const", ifc.ExmAlu, 32'd9);

    // $0 destination never forwards
    @(negedge clk); idle();
    ifc.data1 = 32'h11; ifc.Ex = 4'b1000; ifc.RegRd = 0; ifc.Wb = 2'b10;
    cycle("fwd0_setup");
    @(negedge clk); idle();
    ifc.data1 = 32'h30; ifc.Ex = 4'b1000; ifc.RegRd = 1;
    cycle("fwd0");
    check("fwd0.const", ifc.ExmAlu, 32'h30);

    // signed overflow on add, then slt -1 < 1
    @(negedge clk); idle();
    ifc.data1 = 32'h7FFF_FFFF; ifc.data2 = 1; ifc.Ex = 4'b1100; ifc.Exsign_extend = 32'h20;
    cycle("ovf");
    check("ovf.alu", ifc.ExmAlu, 32'h8000_0000);
    check("ovf.flag", 32'(ifc.ExmOvf), 32'd1);
    @(negedge clk); idle();
    ifc.data1 = 32'hFFFF_FFFF; ifc.data2 = 1; ifc.Ex = 4'b1100; ifc.Exsign_extend = 32'h2A;
    cycle("slt");
    check("slt.const", ifc.ExmAlu, 32'd1);

    // flush beats stall; stall alone holds
    @(negedge clk); idle();
    ifc.MemW = 1; ifc.Wb = 2'b10; ifc.data1 = 3; ifc.stall = 1; ifc.flush = 1;
    cycle("flush");
    check("flush.memw", 32'(ifc.ExmMemW), 32'd0);
    check("flush.wb", 32'(ifc.ExmWb), 32'd0);
    check("flush.alu", ifc.ExmAlu, 32'd3);
    @(negedge clk); idle();
    ifc.MemW = 1; ifc.Wb = 2'b11; ifc.data1 = 77; ifc.stall = 1;
    cycle("stall");
    check("stall.alu", ifc.ExmAlu, 32'd3);

    // async reset mid-cycle, then normal load after release
    @(negedge clk); idle();
    ifc.data1 = 8; ifc.Wb = 2'b11; ifc.MemR = 1;
    cycle("pre_rst");
    #2 rst = 1'b1;
    #1;
    m = '0;
    check_all("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst");
    check("post_rst.alu", ifc.ExmAlu, 32'd8);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ifc.Ex = 4'($urandom);
      ifc.MemR = 1'($urandom); ifc.MemW = 1'($urandom); ifc.Wb = 2'($urandom);
      ifc.RegRs = 5'($urandom_range(0, 3)); ifc.RegRt = 5'($urandom_range(0, 3));
      ifc.RegRd = 5'($urandom_range(0, 3));
      ifc.Exsign_extend = $urandom;
      if ($urandom_range(0, 3) != 0) ifc.Exsign_extend[5:0] = functs[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0: ifc.data1 = 32'h7FFF_FFFF;
        1: ifc.data1 = 32'h8000_0000;
        default: ifc.data1 = $urandom;
      endcase
      ifc.data2 = ($urandom_range(0, 3) == 0) ? ifc.data1 : $urandom;
      ifc.WbRegWrite = 1'($urandom); ifc.WbRd = 5'($urandom_range(0, 3)); ifc.WbData = $urandom;
      ifc.stall = ($urandom_range(0, 4) == 0);
      ifc.flush = ($urandom_range(0, 6) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
